// File: rtl/dst_track_pipe_pkg.sv
// Shared pipeline types: destination-register metadata carried through EX/ME/WB
// and the forwarding-select encodings used by the downstream forwarding unit.
package dst_track_pipe_pkg;

  localparam int REG_W = 3;

  typedef struct packed {
    logic             valid;
    logic             load;
    logic [REG_W-1:0] rdst;
  } stage_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rdst;
  } dst_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, load: 1'b0, rdst: '0};

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_ME   = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/dst_track_pipe_if.sv
// Bundle between the ID stage / pipeline control and the destination tracker.
interface dst_track_pipe_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_wr_en;
  logic             id_mem_rd;
  logic [REG_W-1:0] id_rdst;
  logic [REG_W-1:0] id_rsrc1;
  logic             id_rsrc1_used;
  logic [REG_W-1:0] id_rsrc2;
  logic             id_rsrc2_used;
  logic             ex_flush;
  logic             ext_stall;
  logic             stall_id;
  logic             ex_valid;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rdst;
  logic             me_valid;
  logic [REG_W-1:0] me_rdst;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rdst;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  id_valid, id_wr_en, id_mem_rd, id_rdst,
    input  id_rsrc1, id_rsrc1_used, id_rsrc2, id_rsrc2_used,
    input  ex_flush, ext_stall,
    output stall_id, ex_valid, ex_is_load, ex_rdst,
    output me_valid, me_rdst, wb_valid, wb_rdst, stall_cnt
  );

  modport master (
    output id_valid, id_wr_en, id_mem_rd, id_rdst,
    output id_rsrc1, id_rsrc1_used, id_rsrc2, id_rsrc2_used,
    output ex_flush, ext_stall,
    input  stall_id, ex_valid, ex_is_load, ex_rdst,
    input  me_valid, me_rdst, wb_valid, wb_rdst, stall_cnt
  );
endinterface

// File: rtl/dst_track_pipe_load_use_detect.sv
// Combinational load-use detector: the ID instruction reads the register a load
// in EX is about to produce, so ID must wait one cycle for ME forwarding.
module dst_track_pipe_load_use_detect #(
  parameter int REG_W = 3
) (
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rsrc1_i,
  input  logic             id_rsrc1_used_i,
  input  logic [REG_W-1:0] id_rsrc2_i,
  input  logic             id_rsrc2_used_i,
  input  logic             ex_is_load_i,
  input  logic [REG_W-1:0] ex_rdst_i,
  input  logic             ex_flush_i,
  output logic             stall_id_o
);
  logic src1_hit;
  logic src2_hit;
  logic hz;

  assign src1_hit = id_rsrc1_used_i && (id_rsrc1_i == ex_rdst_i);
  assign src2_hit = id_rsrc2_used_i && (id_rsrc2_i == ex_rdst_i);
  assign hz       = ex_is_load_i && (src1_hit || src2_hit) && id_valid_i;

  // A flushed ID instruction is dead, so stalling for it would waste a cycle.
  assign stall_id_o = hz && !ex_flush_i;
endmodule

// File: rtl/dst_track_pipe.sv
// Destination-register tracker for EX/ME/WB: feeds the forwarding unit, inserts
// a bubble on load-use, honours branch flush and the global freeze.
module dst_track_pipe #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dst_track_pipe_if.slave         bus
);
  import dst_track_pipe_pkg::*;

  stage_t           id_entry;
  stage_t           ex_q, ex_d;
  dst_t             me_q, me_d;
  dst_t             wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_id;

  dst_track_pipe_load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .id_valid_i      (bus.id_valid),
    .id_rsrc1_i      (bus.id_rsrc1),
    .id_rsrc1_used_i (bus.id_rsrc1_used),
    .id_rsrc2_i      (bus.id_rsrc2),
    .id_rsrc2_used_i (bus.id_rsrc2_used),
    .ex_is_load_i    (ex_q.load),
    .ex_rdst_i       (ex_q.rdst),
    .ex_flush_i      (bus.ex_flush),
    .stall_id_o      (stall_id)
  );

  always_comb begin
    id_entry.valid = bus.id_valid && bus.id_wr_en;
    id_entry.load  = bus.id_valid && bus.id_wr_en && bus.id_mem_rd;
    id_entry.rdst  = bus.id_rdst;

    // NOTE: every next-state signal defaults to "hold" first, so no path leaves it unassigned (no latch).
    ex_d  = ex_q;
    me_d  = me_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;

    // While frozen the branch stays in EX and re-asserts ex_flush later.
    if (!bus.ext_stall) begin
      wb_d = me_q;
      me_d = '{valid: ex_q.valid, rdst: ex_q.rdst};
      ex_d = (bus.ex_flush || stall_id) ? BUBBLE : id_entry;
      if (stall_id && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      me_q  <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      me_q  <= me_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall_id   = stall_id;
  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_is_load = ex_q.load;
  assign bus.ex_rdst    = ex_q.rdst;
  assign bus.me_valid   = me_q.valid;
  assign bus.me_rdst    = me_q.rdst;
  assign bus.wb_valid   = wb_q.valid;
  assign bus.wb_rdst    = wb_q.rdst;
  assign bus.stall_cnt  = cnt_q;
endmodule
